// File: rtl/cpu_error_pkg.sv
// Shared CPU error code constants and the capture FSM state encoding.
package cpu_error_pkg;
    localparam logic [3:0] NO_ERROR             = 4'd0;
    localparam logic [3:0] ERROR_DIV_BY_ZERO    = 4'd1;
    localparam logic [3:0] ERROR_MEM_ACCESS_ERR = 4'd2;
    localparam logic [3:0] ERROR_IS_OPCODE_ERR  = 4'd3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HALT       = 2'd1,
        WAIT_CLEAR = 2'd2
    } ecu_state_t;
endpackage

// File: rtl/error_history_buf.sv
// Circular log of captured {code, pc}; read index 0 is the most recent entry.
// Unwritten slots read as 0 because every slot is cleared on reset.
module error_history_buf #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [3:0]               wr_code,
    input  logic [PC_W-1:0]          wr_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [3:0]               rd_code,
    output logic [PC_W-1:0]          rd_pc
);
    localparam int IW = $clog2(DEPTH);

    logic [3:0]      code_mem [DEPTH];
    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [IW-1:0]   wr_ptr;
    logic [IW-1:0]   rd_ptr;

    // Write the newest capture and advance the pointer; wraps naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                code_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (wr_en) begin
            code_mem[wr_ptr] <= wr_code;
            pc_mem[wr_ptr]   <= wr_pc;
            wr_ptr           <= wr_ptr + IW'(1);
        end
    end

    // Index backwards from the last written slot.
    always_comb begin
        rd_ptr  = wr_ptr - IW'(1) - rd_idx;
        rd_code = code_mem[rd_ptr];
        rd_pc   = pc_mem[rd_ptr];
    end
endmodule

// File: rtl/error_capture_unit.sv
// Latches the first CPU error and its PC, halts the CPU until acknowledged,
// and re-arms only after the error source clears.
// Optional history log enabled by defining ERROR_CAPTURE_HISTORY_EN.
module error_capture_unit
    import cpu_error_pkg::*;
#(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 8,
    parameter int HIST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [3:0]                    cpu_error,
    input  logic [PC_W-1:0]               cpu_pc,
    input  logic                          err_ack,
    output logic                          cpu_stop,
    output logic                          err_valid,
    output logic [3:0]                    err_code,
    output logic [PC_W-1:0]               err_pc,
    output logic [CNT_W-1:0]              err_count,
    output logic                          err_lost,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [3:0]                    hist_code,
    output logic [PC_W-1:0]               hist_pc
);
    ecu_state_t state, next_state;
    logic       capture;

    assign capture   = (state == RUN) && (cpu_error != NO_ERROR);
    // Both flags decode straight from the state register, so they stay glitch-free.
    assign cpu_stop  = (state != RUN);
    assign err_valid = (state == HALT);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= next_state;
    end

    // Next state: ack wins over a fresh error in HALT; re-arm needs a quiet cycle.
    always_comb begin
        next_state = state;
        case (state)
            RUN:        if (cpu_error != NO_ERROR) next_state = HALT;
            HALT:       if (err_ack)               next_state = WAIT_CLEAR;
            WAIT_CLEAR: if (cpu_error == NO_ERROR) next_state = RUN;
            default:    next_state = RUN;
        endcase
    end

    // Capture registers, saturating counter and sticky lost flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_code  <= '0;
            err_pc    <= '0;
            err_count <= '0;
            err_lost  <= 1'b0;
        end else begin
            if (capture) begin
                err_code <= cpu_error;
                err_pc   <= cpu_pc;
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
            if (state != RUN && cpu_error != NO_ERROR && cpu_error != err_code)
                err_lost <= 1'b1;
        end
    end

`ifdef ERROR_CAPTURE_HISTORY_EN
    error_history_buf #(
        .PC_W  (PC_W),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (capture),
        .wr_code (cpu_error),
        .wr_pc   (cpu_pc),
        .rd_idx  (hist_idx),
        .rd_code (hist_code),
        .rd_pc   (hist_pc)
    );
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_code       = '0;
    assign hist_pc         = '0;
`endif
endmodule
